// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel receiver with a start strobe for frame alignment
// and a valid/ready holding register. Define PARITY_CHECK_EN for a trailing even-parity bit.
module sipo_deserializer #(
    parameter int WIDTH = 8,
    parameter int SEL   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             start,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    localparam logic [SEL-1:0] LAST_CNT = SEL'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [SEL-1:0]   cnt;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             complete;
`ifdef PARITY_CHECK_EN
    logic             par_bad;
`endif

    assign shifted = {shreg[WIDTH-2:0], ser_in};
    assign busy    = (state != IDLE);

    // A start strobe always wins: it aborts any frame, even on what would be its last edge.
    always_comb begin
`ifdef PARITY_CHECK_EN
        word     = shreg;
        complete = ser_en && !start && (state == PARITY);
        par_bad  = ^{shreg, ser_in};
`else
        word     = shifted;
        complete = ser_en && !start && (state == SHIFT) && (cnt == LAST_CNT);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            par_out   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            if (ser_en) begin
                if (start) begin
                    frame_err <= (state != IDLE);
                    shreg     <= shifted;
                    cnt       <= SEL'(1);
                    state     <= SHIFT;
                end else if (state == SHIFT) begin
                    shreg <= shifted;
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
`ifdef PARITY_CHECK_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + SEL'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                else if (state == PARITY) begin
                    parity_err <= par_bad;
                    state      <= IDLE;
                end
`endif
            end

            // Holding register: a new word only lands if the old one is gone or leaving now.
            if (complete) begin
                if (!out_valid || out_ready) begin
                    par_out   <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed scoreboard bench for sipo_deserializer; the reference
// model collects frame bits in a queue and rebuilds words arithmetically.
module tb_sipo_deserializer;
    localparam int WIDTH = 8;
    localparam int SEL   = 3;
`ifdef PARITY_CHECK_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clock;
    logic             reset;
    logic             ser_in;
    logic             ser_en;
    logic             start;
    logic [WIDTH-1:0] par_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    sipo_deserializer #(.WIDTH(WIDTH), .SEL(SEL)) dut (
        .clock(clock),
        .reset(reset),
        .ser_in(ser_in),
        .ser_en(ser_en),
        .start(start),
        .par_out(par_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .overrun(overrun),
        .frame_err(frame_err)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int tgt;
        bit v;
        bit ovr;
        bit ferr;
        bit bsy;
        bit perr;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] word_q[$];
    bit               fb[$];
    bit               inframe = 0;
    bit               occ = 0;
    int               tests = 0;
    int               fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and predict what the DUT shows after the coming edge.
    task automatic step(input bit en, input bit din, input bit st, input bit rdy);
        exp_t             e;
        bit               comp;
        logic [WIDTH-1:0] w;
        @(negedge clock);
        #1;
        ser_en = en; ser_in = din; start = st; out_ready = rdy;
        e.tgt = cyc + 1; e.v = 0; e.ovr = 0; e.ferr = 0; e.bsy = 0; e.perr = 0;
        comp = 0;
        w = '0;
        if (en) begin
            if (st) begin
                e.ferr = inframe;
                fb.delete();
                fb.push_back(din);
                inframe = 1;
            end else if (inframe) begin
                fb.push_back(din);
            end
            if (inframe && fb.size() == FLEN) begin
                comp = 1;
                inframe = 0;
                for (int i = 0; i < WIDTH; i++) w = WIDTH'(w * 2 + 32'(fb[i]));
`ifdef PARITY_CHECK_EN
                for (int i = 0; i < FLEN; i++) e.perr = e.perr ^ fb[i];
`endif
            end
        end
        if (comp) begin
            if (!occ || rdy) begin
                word_q.push_back(w);
                occ = 1;
            end else begin
                e.ovr = 1;
            end
        end else if (occ && rdy) begin
            occ = 0;
        end
        e.v = occ;
        e.bsy = inframe;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, 1'($urandom()), 1'($urandom()), rdy);
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, w[WIDTH-1-i], i == 0, rdy);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input bit rdy_rest,
                             input bit rdy_last, input bit par_ok);
        bit b;
        for (int i = 0; i < FLEN; i++) begin
            b = (i < WIDTH) ? w[WIDTH-1-i] : ((^w) ^ !par_ok);
            step(1'b1, b, i == 0, (i == FLEN - 1) ? rdy_last : rdy_rest);
            if (i != FLEN - 1) repeat (gap) step(1'b0, 1'($urandom()), 1'b0, rdy_rest);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_par_out", par_out, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
`ifdef PARITY_CHECK_EN
        check("rst_parity_err", parity_err, 0);
`endif
    endtask

    // Monitor: per-cycle flags from exp_q, delivered words from word_q on each handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
                e = exp_q.pop_front();
                if (e.tgt == cyc) begin
                    check("out_valid", out_valid, e.v);
                    check("overrun", overrun, e.ovr);
                    check("frame_err", frame_err, e.ferr);
                    check("busy", busy, e.bsy);
`ifdef PARITY_CHECK_EN
                    check("parity_err", parity_err, e.perr);
`endif
                end
            end
            if (!reset && out_valid && out_ready) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word", par_out, 32'hFFFF_FFFF);
                end else begin
                    check("word", par_out, word_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ser_in = 1'b0; ser_en = 1'b0; start = 1'b0; out_ready = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clock);
        #1;
        reset = 1'b0;

        // Reset in the middle of a frame, then a clean frame.
        send_bits(8'hC3, 3, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1; ser_en = 1'b0; start = 1'b0;
        exp_q.delete(); word_q.delete(); fb.delete(); inframe = 0; occ = 0;
        #1;
        check_reset_outputs();
        @(negedge clock);
        #1;
        reset = 1'b0;
        send_word(8'hA5, 0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Basic frame held until ready.
        send_word(8'hFC, 0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);
        idle(2, 1'b1);

        // Gapped strobe.
        send_word(8'h3C, 2, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Back-to-back: overrun, then ready on the completing edge.
        send_word(8'h81, 0, 1'b0, 1'b0, 1'b1);
        send_word(8'h7E, 0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        send_word(8'h81, 0, 1'b0, 1'b0, 1'b1);
        send_word(8'h7E, 0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Resync: start arrives on the 5th bit.
        send_bits(8'hAA, 4, 1'b1);
        send_word(8'hF0, 0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

`ifdef PARITY_CHECK_EN
        send_word(8'h07, 0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        send_word(8'h07, 0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
`endif

        // Random traffic with mid-frame starts, gaps and backpressure.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom()), 1'($urandom()), ($urandom() % 10) == 0, ($urandom() % 3) == 0);
        end

        idle(4, 1'b1);
        check("drain_words_left", word_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
